// File: rtl/uart_tx_ctrl.sv
// ============================================================================
//  Module      : uart_tx_ctrl
//  Description : Avalon-MM UART transmitter with byte FIFO, programmable
//                baud divisor and 8N1 framing state machine.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_ctrl #(
    parameter int FIFO_DEPTH  = 8,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 434
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        txd,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] DIV_MIN_C = DIV_W'(2);
    localparam logic [DIV_W-1:0] DIV_RST_C = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE_C     = DIV_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   div_lat_q, div_lat_d;
    logic [7:0]         shift_q, shift_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic               txd_q, txd_d;
    logic               irq_q, irq_d;
    logic [1:0]         ctrl_q, ctrl_d;
    logic               ovf_q, ovf_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [7:0]         fifo_mem [FIFO_DEPTH];

    logic               wr_en;
    logic               push;
    logic               push_ok;
    logic               pop;
    logic               empty;
    logic               full;
    logic               tx_en;
    logic [DIV_W-1:0]   wr_div;
    logic               unused_wd;

    assign unused_wd = ^writedata;

    always_comb begin
        wr_en   = chipselect && !write_n;
        push    = wr_en && (address == 2'd0);
        empty   = (count_q == '0);
        full    = (count_q == DEPTH_C);
        tx_en   = ctrl_q[0];
        wr_div  = writedata[DIV_W-1:0];

        // Framing FSM; pop and divisor latch happen on the same edge.
        pop       = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_lat_d = div_lat_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        txd_d     = txd_q;
        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (tx_en && !empty) begin
                    pop       = 1'b1;
                    state_d   = S_START;
                    shift_d   = fifo_mem[rd_ptr_q];
                    div_lat_d = div_q;
                    cnt_d     = div_q;
                    txd_d     = 1'b0;
                end
            end
            S_START: begin
                if (cnt_q == ONE_C) begin
                    state_d   = S_DATA;
                    cnt_d     = div_lat_q;
                    bit_idx_d = 3'd0;
                    txd_d     = shift_q[0];
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end
            S_DATA: begin
                if (cnt_q == ONE_C) begin
                    cnt_d = div_lat_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        txd_d     = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end
            default: begin
                if (cnt_q == ONE_C) begin
                    if (tx_en && !empty) begin
                        pop       = 1'b1;
                        state_d   = S_START;
                        shift_d   = fifo_mem[rd_ptr_q];
                        div_lat_d = div_q;
                        cnt_d     = div_q;
                        txd_d     = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end
        endcase

        // A full FIFO still accepts a push when a pop frees a slot this edge.
        push_ok  = push && (!full || pop);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CW'(1);
        end

        ovf_d = ovf_q;
        if (push && full && !pop) begin
            ovf_d = 1'b1;
        end else if (wr_en && (address == 2'd1) && writedata[3]) begin
            ovf_d = 1'b0;
        end

        div_d = div_q;
        if (wr_en && (address == 2'd2)) begin
            div_d = (wr_div < DIV_MIN_C) ? DIV_MIN_C : wr_div;
        end

        ctrl_d = ctrl_q;
        if (wr_en && (address == 2'd3)) begin
            ctrl_d = writedata[1:0];
        end

        irq_d = ctrl_d[1] && (count_d == '0) && (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= DIV_RST_C;
            div_lat_q <= DIV_RST_C;
            shift_q   <= '0;
            bit_idx_q <= '0;
            txd_q     <= 1'b1;
            irq_q     <= 1'b0;
            ctrl_q    <= '0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            div_lat_q <= div_lat_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            txd_q     <= txd_d;
            irq_q     <= irq_d;
            ctrl_q    <= ctrl_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (reset_n && push_ok) begin
            fifo_mem[wr_ptr_q] <= writedata[7:0];
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd1:    readdata = {16'h0000, 8'(count_q), 4'h0,
                                 ovf_q, full, empty, (state_q != S_IDLE)};
            2'd2:    readdata = 32'(div_q);
            2'd3:    readdata = {30'd0, ctrl_q};
            default: readdata = '0;
        endcase
    end

    assign txd = txd_q;
    assign irq = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
// ============================================================================
//  Module      : tb_uart_tx_ctrl
//  Description : Scoreboard bench for uart_tx_ctrl: expected frames and
//                register/pin values are queued and checked by monitors.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        txd;
    logic        irq;

    uart_tx_ctrl #(
        .FIFO_DEPTH  (8),
        .DIV_W       (16),
        .DEFAULT_DIV (434)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .txd        (txd),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         div;
        int         nsamp;
        int         exp_start;
        bit         b2b;
    } frame_t;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        logic [31:0] mask;
        string       name;
    } probe_t;

    frame_t fq[$];
    probe_t pq[$];
    int     n_assert = 0;
    int     n_fail   = 0;
    logic   pr_vld   = 1'b0;
    bit     in_frame = 1'b0;
    int     last_end = 0;

    // Register / pin monitor
    probe_t      pe;
    logic [31:0] pact;
    always @(negedge clk) begin
        if (pr_vld) begin
            pe = pq.pop_front();
            case (pe.sel)
                0:       pact = readdata;
                1:       pact = {31'd0, irq};
                default: pact = {31'd0, txd};
            endcase
            n_assert++;
            if ((pact & pe.mask) !== (pe.exp & pe.mask)) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                         pe.name, pact & pe.mask, pe.exp & pe.mask, cyc);
            end
        end
    end

    // Serial frame monitor
    frame_t fr;
    logic   prev_txd = 1'b1;
    initial begin : frame_mon
        bit   bad;
        int   bad_s;
        logic bad_v, bad_e, eb;
        int   k;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && txd === 1'b0 && prev_txd === 1'b1) begin
                if (fq.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL stray_start: txd fell at cycle %0d, no frame expected", cyc);
                    prev_txd = txd;
                end else begin
                    fr = fq.pop_front();
                    in_frame = 1'b1;
                    if (fr.exp_start >= 0) begin
                        n_assert++;
                        if (cyc != fr.exp_start) begin
                            n_fail++;
                            $display("FAIL start_time[0x%02h]: start at cycle %0d expected %0d",
                                     fr.data, cyc, fr.exp_start);
                        end
                    end
                    if (fr.b2b) begin
                        n_assert++;
                        if (cyc != last_end + 1) begin
                            n_fail++;
                            $display("FAIL back_to_back[0x%02h]: start at cycle %0d expected %0d",
                                     fr.data, cyc, last_end + 1);
                        end
                    end
                    bad = 1'b0; bad_s = -1; bad_v = 1'b0; bad_e = 1'b0;
                    for (int s = 0; s < fr.nsamp; s++) begin
                        if (s > 0) @(negedge clk);
                        k  = s / fr.div;
                        eb = (k == 0) ? 1'b0 : (k >= 9) ? 1'b1 : fr.data[k-1];
                        if (txd !== eb && !bad) begin
                            bad = 1'b1; bad_s = s; bad_v = txd; bad_e = eb;
                        end
                    end
                    n_assert++;
                    if (bad) begin
                        n_fail++;
                        $display("FAIL frame[0x%02h]: sample %0d txd=%b expected %b",
                                 fr.data, bad_s, bad_v, bad_e);
                    end
                    last_end = cyc;
                    prev_txd = txd;
                    in_frame = 1'b0;
                end
            end else begin
                prev_txd = txd;
            end
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d, output int w);
        @(posedge clk); #1;
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
        w = cyc;
    endtask

    // sel: 0 readdata at address a, 1 irq, 2 txd. target<0 means next cycle.
    task automatic probe(input int sel, input logic [1:0] a, input logic [31:0] exp,
                         input logic [31:0] mask, input string nm,
                         input int target, input bit now);
        if (!now) begin
            @(posedge clk); #1;
            while (target >= 0 && cyc < target) begin
                @(posedge clk); #1;
            end
        end
        address = a; chipselect = (sel == 0); write_n = 1'b1;
        pq.push_back('{sel, exp, mask, nm});
        pr_vld = 1'b1;
        @(negedge clk); #1;
        pr_vld = 1'b0; chipselect = 1'b0;
    endtask

    task automatic push_frame(input logic [7:0] d, input int div, input int nsamp,
                              input int st, input bit b2b);
        fq.push_back('{d, div, nsamp, st, b2b});
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while ((fq.size() != 0 || in_frame) && t < budget) begin
            @(posedge clk);
            t++;
        end
        n_assert++;
        if (fq.size() != 0 || in_frame) begin
            n_fail++;
            $display("FAIL drain: %0d frames still pending after %0d cycles", fq.size(), budget);
        end
        repeat (4) @(posedge clk);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int w, w2;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        probe(0, 2'd0, 32'h0,        32'hFFFF_FFFF, "rst_txdata",  -1, 0);
        probe(0, 2'd1, 32'h0000_0002, 32'hFFFF_FFFF, "rst_status",  -1, 0);
        probe(0, 2'd2, 32'd434,      32'hFFFF_FFFF, "rst_divisor", -1, 0);
        probe(0, 2'd3, 32'h0,        32'hFFFF_FFFF, "rst_control", -1, 0);
        probe(2, 2'd0, 32'h1,        32'h1,         "rst_txd",     -1, 0);
        probe(1, 2'd0, 32'h0,        32'h1,         "rst_irq",     -1, 0);

        // Single frame 0xA5 at divisor 4
        wr(2'd2, 32'd4, w);
        wr(2'd3, 32'd1, w);
        wr(2'd0, 32'hA5, w);
        push_frame(8'hA5, 4, 40, w + 1, 0);
        probe(0, 2'd1, 32'h1, 32'h1, "busy_first",   w + 1,  0);
        probe(0, 2'd1, 32'h1, 32'h1, "busy_last",    w + 40, 0);
        probe(0, 2'd1, 32'h0, 32'h1, "busy_cleared", w + 41, 0);
        drain(200);

        // Overflow then back-to-back burst at divisor 2
        wr(2'd3, 32'd0, w);
        wr(2'd2, 32'd2, w);
        for (int i = 1; i <= 9; i++) wr(2'd0, i, w);
        probe(0, 2'd1, 32'h0000_080C, 32'hFFFF_FFFF, "full_overflow", -1, 0);
        wr(2'd3, 32'd1, w);
        for (int i = 1; i <= 8; i++)
            push_frame(8'(i), 2, 20, (i == 1) ? w + 1 : -1, (i != 1));
        drain(400);
        probe(0, 2'd1, 32'h0000_000A, 32'hFFFF_FFFF, "drained_ovf_sticky", -1, 0);
        wr(2'd1, 32'h8, w);
        probe(0, 2'd1, 32'h0000_0002, 32'hFFFF_FFFF, "ovf_cleared", -1, 0);

        // Divisor clamp and mid-frame change
        wr(2'd2, 32'd0, w);
        probe(0, 2'd2, 32'd2, 32'hFFFF_FFFF, "div_clamp", -1, 0);
        wr(2'd2, 32'd8, w);
        wr(2'd0, 32'h96, w);
        push_frame(8'h96, 8, 80, w + 1, 0);
        wr(2'd0, 32'h3C, w2);
        wr(2'd2, 32'd3, w2);
        push_frame(8'h3C, 3, 30, -1, 1);
        probe(0, 2'd2, 32'd3, 32'hFFFF_FFFF, "div_readback", -1, 0);
        drain(300);

        // Interrupt behaviour
        wr(2'd2, 32'd4, w);
        wr(2'd3, 32'd3, w);
        probe(1, 2'd0, 32'h1, 32'h1, "irq_idle_empty", -1, 1);
        wr(2'd0, 32'hC3, w);
        push_frame(8'hC3, 4, 40, w + 1, 0);
        probe(1, 2'd0, 32'h0, 32'h1, "irq_drop_on_push", -1, 1);
        probe(1, 2'd0, 32'h0, 32'h1, "irq_busy",        w + 5,  0);
        probe(1, 2'd0, 32'h0, 32'h1, "irq_stop_last",   w + 40, 0);
        probe(1, 2'd0, 32'h1, 32'h1, "irq_after_stop",  w + 41, 0);
        wr(2'd0, 32'h81, w2);
        push_frame(8'h81, 4, 40, w2 + 1, 0);
        probe(1, 2'd0, 32'h0, 32'h1, "irq_drop_second", -1, 1);
        drain(200);
        wr(2'd3, 32'd1, w);
        probe(1, 2'd0, 32'h0, 32'h1, "irq_disabled", -1, 1);

        // Reset during DATA aborts the frame
        wr(2'd0, 32'h55, w);
        push_frame(8'h55, 4, 10, w + 1, 0);
        repeat (10) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        probe(2, 2'd0, 32'h1, 32'h1, "txd_after_reset", -1, 1);
        probe(0, 2'd1, 32'h0000_0002, 32'hFFFF_FFFF, "status_after_reset",  -1, 0);
        probe(0, 2'd2, 32'd434,       32'hFFFF_FFFF, "divisor_after_reset", -1, 0);
        probe(0, 2'd3, 32'h0,         32'hFFFF_FFFF, "control_after_reset", -1, 0);
        wr(2'd3, 32'd1, w);
        repeat (60) @(posedge clk);
        probe(0, 2'd1, 32'h0000_0002, 32'hFFFF_FFFF, "no_residual_frame", -1, 0);
        drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
